// File: rtl/main_controller_pkg.sv
// Shared encodings for the multi-cycle controller and its datapath: FSM states,
// opcodes, instruction classes and the pcSelect / memToReg / access-size codes.
package main_controller_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_ILLEGAL
  } instr_class_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] PCSEL_PLUS4  = 2'b00;
  localparam logic [1:0] PCSEL_BRANCH = 2'b01;
  localparam logic [1:0] PCSEL_JAL    = 2'b10;
  localparam logic [1:0] PCSEL_JALR   = 2'b11;

  localparam logic [1:0] WBSEL_ALU = 2'b00;
  localparam logic [1:0] WBSEL_MEM = 2'b01;
  localparam logic [1:0] WBSEL_PC  = 2'b10;
  localparam logic [1:0] WBSEL_IMM = 2'b11;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_INVALID = 2'b11;

  // Classes whose second ALU operand is the immediate rather than rs2.
  function automatic logic uses_imm_operand(input instr_class_e cls);
    return (cls == CLS_I) || (cls == CLS_LOAD) || (cls == CLS_STORE) ||
           (cls == CLS_JALR) || (cls == CLS_AUIPC);
  endfunction

endpackage

// File: rtl/main_controller_opcode_decoder.sv
// Combinational opcode classifier: maps opcode and access-size field to an
// instruction class plus an illegal flag.
module opcode_decoder
  import main_controller_pkg::*;
(
  input  logic [6:0]   opcode_i,
  input  logic [1:0]   size_i,
  output instr_class_e instr_class_o,
  output logic         illegal_o
);

  always_comb begin
    instr_class_o = CLS_ILLEGAL;
    case (opcode_i)
      OP_R:      instr_class_o = CLS_R;
      OP_I:      instr_class_o = CLS_I;
      OP_LOAD:   instr_class_o = CLS_LOAD;
      OP_STORE:  instr_class_o = CLS_STORE;
      OP_BRANCH: instr_class_o = CLS_BRANCH;
      OP_JAL:    instr_class_o = CLS_JAL;
      OP_JALR:   instr_class_o = CLS_JALR;
      OP_LUI:    instr_class_o = CLS_LUI;
      OP_AUIPC:  instr_class_o = CLS_AUIPC;
      default:   instr_class_o = CLS_ILLEGAL;
    endcase
  end

  // Memory accesses only support byte/half/word; the fourth size code is rejected.
  always_comb begin
    illegal_o = (instr_class_o == CLS_ILLEGAL) ||
                (((instr_class_o == CLS_LOAD) || (instr_class_o == CLS_STORE)) &&
                 (size_i == SIZE_INVALID));
  end

endmodule

// File: rtl/main_controller.sv
// Multi-cycle Moore controller: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing with
// a retired-instruction counter.
module main_controller
  import main_controller_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] irOut,
  input  logic              comparatorOut,
  output logic              irEn,
  output logic              pcEn,
  output logic              regWrite,
  output logic              aluSrc,
  output logic              ramRdEn,
  output logic              ramWrEn,
  output logic              isByte,
  output logic              isHalf,
  output logic              isWord,
  output logic [1:0]        pcSelect,
  output logic [1:0]        memToReg,
  output logic              halted,
  output logic [DWIDTH-1:0] retired
);

  state_e            state_q, state_d;
  logic              rst_hold_q;
  logic [DWIDTH-1:0] retired_q;
  instr_class_e      cls;
  logic              illegal;
  logic [1:0]        size;
  logic              unused_inputs;

  assign size = irOut[13:12];

  // The branch decision is taken in the datapath; the controller only selects it.
  assign unused_inputs = ^{comparatorOut, irOut[11:7], irOut[DWIDTH-1:14]};

  opcode_decoder u_opcode_decoder (
    .opcode_i      (irOut[6:0]),
    .size_i        (size),
    .instr_class_o (cls),
    .illegal_o     (illegal)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = illegal ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if ((cls == CLS_LOAD) || (cls == CLS_STORE)) state_d = ST_MEM;
        else if (cls == CLS_BRANCH)                  state_d = ST_FETCH;
        else                                         state_d = ST_WB;
      end
      ST_MEM:    state_d = (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  // rst_hold_q marks the cycle(s) spent in reset: state is FETCH but all outputs
  // stay quiet until the first edge that samples reset released.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_FETCH;
      rst_hold_q <= 1'b1;
      retired_q  <= '0;
    end else begin
      rst_hold_q <= 1'b0;
      if (!rst_hold_q) state_q <= state_d;
      if (pcEn) retired_q <= retired_q + DWIDTH'(1);
    end
  end

  always_comb begin
    irEn     = 1'b0;
    pcEn     = 1'b0;
    regWrite = 1'b0;
    aluSrc   = 1'b0;
    ramRdEn  = 1'b0;
    ramWrEn  = 1'b0;
    isByte   = 1'b0;
    isHalf   = 1'b0;
    isWord   = 1'b0;
    pcSelect = PCSEL_PLUS4;
    memToReg = WBSEL_ALU;
    if (!rst_hold_q) begin
      if ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB)) begin
        aluSrc = uses_imm_operand(cls);
      end
      if (((state_q == ST_MEM) || (state_q == ST_WB)) &&
          ((cls == CLS_LOAD) || (cls == CLS_STORE))) begin
        isByte = (size == SIZE_BYTE);
        isHalf = (size == SIZE_HALF);
        isWord = (size == SIZE_WORD);
      end
      case (state_q)
        ST_FETCH: irEn = 1'b1;
        ST_EXEC: begin
          if (cls == CLS_BRANCH) begin
            pcEn     = 1'b1;
            pcSelect = PCSEL_BRANCH;
          end
        end
        ST_MEM: begin
          if (cls == CLS_LOAD) begin
            ramRdEn = 1'b1;
          end else begin
            ramWrEn = 1'b1;
            pcEn    = 1'b1;
          end
        end
        ST_WB: begin
          regWrite = 1'b1;
          pcEn     = 1'b1;
          case (cls)
            CLS_LOAD: memToReg = WBSEL_MEM;
            CLS_LUI:  memToReg = WBSEL_IMM;
            CLS_JAL: begin
              pcSelect = PCSEL_JAL;
              memToReg = WBSEL_PC;
            end
            CLS_JALR: begin
              pcSelect = PCSEL_JALR;
              memToReg = WBSEL_PC;
            end
            default: memToReg = WBSEL_ALU;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign halted  = (state_q == ST_HALT);
  assign retired = retired_q;

endmodule

// File: tb/tb_main_controller.sv
// Directed bench for main_controller: per-scenario tasks compare the packed
// control outputs cycle by cycle against hand-written vectors.
module tb_main_controller;

  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic [DW-1:0] irOut;
  logic          comparatorOut;
  logic          irEn, pcEn, regWrite, aluSrc, ramRdEn, ramWrEn;
  logic          isByte, isHalf, isWord, halted;
  logic [1:0]    pcSelect, memToReg;
  logic [DW-1:0] retired;
  logic [12:0]   outs;

  int total = 0;
  int bad   = 0;
  int exp_ret = 0;

  // field order: irEn pcEn regWrite aluSrc ramRdEn ramWrEn isByte isHalf isWord pcSelect memToReg
  localparam logic [12:0] V_ZERO    = 13'b0_0_0_0_0_0_0_0_0_00_00;
  localparam logic [12:0] V_FETCH   = 13'b1_0_0_0_0_0_0_0_0_00_00;
  localparam logic [12:0] V_ALUSRC  = 13'b0_0_0_1_0_0_0_0_0_00_00;
  localparam logic [12:0] V_WB_R    = 13'b0_1_1_0_0_0_0_0_0_00_00;
  localparam logic [12:0] V_WB_IMM  = 13'b0_1_1_1_0_0_0_0_0_00_00;
  localparam logic [12:0] V_WB_LUI  = 13'b0_1_1_0_0_0_0_0_0_00_11;
  localparam logic [12:0] V_WB_JAL  = 13'b0_1_1_0_0_0_0_0_0_10_10;
  localparam logic [12:0] V_WB_JALR = 13'b0_1_1_1_0_0_0_0_0_11_10;
  localparam logic [12:0] V_MEM_LW  = 13'b0_0_0_1_1_0_0_0_1_00_00;
  localparam logic [12:0] V_WB_LW   = 13'b0_1_1_1_0_0_0_0_1_00_01;
  localparam logic [12:0] V_MEM_LH  = 13'b0_0_0_1_1_0_0_1_0_00_00;
  localparam logic [12:0] V_WB_LH   = 13'b0_1_1_1_0_0_0_1_0_00_01;
  localparam logic [12:0] V_MEM_SW  = 13'b0_1_0_1_0_1_0_0_1_00_00;
  localparam logic [12:0] V_MEM_SB  = 13'b0_1_0_1_0_1_1_0_0_00_00;
  localparam logic [12:0] V_EX_BR   = 13'b0_1_0_0_0_0_0_0_0_01_00;

  main_controller #(.DWIDTH(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .irOut         (irOut),
    .comparatorOut (comparatorOut),
    .irEn          (irEn),
    .pcEn          (pcEn),
    .regWrite      (regWrite),
    .aluSrc        (aluSrc),
    .ramRdEn       (ramRdEn),
    .ramWrEn       (ramWrEn),
    .isByte        (isByte),
    .isHalf        (isHalf),
    .isWord        (isWord),
    .pcSelect      (pcSelect),
    .memToReg      (memToReg),
    .halted        (halted),
    .retired       (retired)
  );

  assign outs = {irEn, pcEn, regWrite, aluSrc, ramRdEn, ramWrEn,
                 isByte, isHalf, isWord, pcSelect, memToReg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    irOut = '0;
    comparatorOut = 1'b0;
    cyc();
    cyc();
    total++; if (outs !== V_ZERO) begin bad++; $display("FAIL reset_outs got=%b want=%b", outs, V_ZERO); end
    total++; if (retired !== 32'd0) begin bad++; $display("FAIL reset_retired got=%0d want=0", retired); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
    reset = 1'b1;
    cyc();
    total++; if (outs !== V_FETCH) begin bad++; $display("FAIL reset_first_fetch got=%b want=%b", outs, V_FETCH); end
    total++; if (retired !== 32'd0) begin bad++; $display("FAIL reset_release_retired got=%0d want=0", retired); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_release_halted got=%b want=0", halted); end
    exp_ret = 0;
  endtask

  // ADD, ADDI, AUIPC, LUI, JAL, JALR: FETCH, DECODE, EXEC, WB
  task automatic test_wb_ops();
    logic [31:0] ins [6] = '{32'h002081B3, 32'h00100093, 32'h00000097,
                             32'h000000B7, 32'h0000006F, 32'h00008067};
    logic [12:0] ex  [6] = '{V_ZERO, V_ALUSRC, V_ALUSRC, V_ZERO, V_ZERO, V_ALUSRC};
    logic [12:0] wb  [6] = '{V_WB_R, V_WB_IMM, V_WB_IMM, V_WB_LUI, V_WB_JAL, V_WB_JALR};
    logic [12:0] exp_v [4];
    for (int k = 0; k < 6; k++) begin
      irOut = ins[k];
      #1;
      exp_v = '{V_FETCH, V_ZERO, ex[k], wb[k]};
      for (int c = 0; c < 4; c++) begin
        total++;
        if (outs !== exp_v[c]) begin
          bad++;
          $display("FAIL wb_ops ins=%h cycle=%0d got=%b want=%b", ins[k], c, outs, exp_v[c]);
        end
        cyc();
      end
      exp_ret++;
      total++;
      if (retired !== 32'(exp_ret)) begin bad++; $display("FAIL wb_ops_retired ins=%h got=%0d want=%0d", ins[k], retired, exp_ret); end
    end
  endtask

  // LW then LH: five cycles each, WB selects data memory
  task automatic test_load();
    logic [31:0] ins [2] = '{32'h0000A103, 32'h00009103};
    logic [12:0] mem [2] = '{V_MEM_LW, V_MEM_LH};
    logic [12:0] wb  [2] = '{V_WB_LW, V_WB_LH};
    logic [12:0] exp_v [5];
    for (int k = 0; k < 2; k++) begin
      irOut = ins[k];
      #1;
      exp_v = '{V_FETCH, V_ZERO, V_ALUSRC, mem[k], wb[k]};
      for (int c = 0; c < 5; c++) begin
        total++;
        if (outs !== exp_v[c]) begin
          bad++;
          $display("FAIL load ins=%h cycle=%0d got=%b want=%b", ins[k], c, outs, exp_v[c]);
        end
        cyc();
      end
      exp_ret++;
      total++;
      if (outs !== V_FETCH) begin bad++; $display("FAIL load_back_to_fetch ins=%h got=%b want=%b", ins[k], outs, V_FETCH); end
      total++;
      if (retired !== 32'(exp_ret)) begin bad++; $display("FAIL load_retired ins=%h got=%0d want=%0d", ins[k], retired, exp_ret); end
    end
  endtask

  // SW then SB: four cycles, pcEn and ramWrEn together in MEM
  task automatic test_store();
    logic [31:0] ins [2] = '{32'h0020A023, 32'h00208023};
    logic [12:0] mem [2] = '{V_MEM_SW, V_MEM_SB};
    logic [12:0] exp_v [4];
    for (int k = 0; k < 2; k++) begin
      irOut = ins[k];
      #1;
      exp_v = '{V_FETCH, V_ZERO, V_ALUSRC, mem[k]};
      for (int c = 0; c < 4; c++) begin
        total++;
        if (outs !== exp_v[c]) begin
          bad++;
          $display("FAIL store ins=%h cycle=%0d got=%b want=%b", ins[k], c, outs, exp_v[c]);
        end
        cyc();
      end
      exp_ret++;
      total++;
      if (outs !== V_FETCH) begin bad++; $display("FAIL store_back_to_fetch ins=%h got=%b want=%b", ins[k], outs, V_FETCH); end
      total++;
      if (retired !== 32'(exp_ret)) begin bad++; $display("FAIL store_retired ins=%h got=%0d want=%0d", ins[k], retired, exp_ret); end
    end
  endtask

  // BEQ with comparator low then high: identical three-cycle sequence
  task automatic test_branch();
    logic [12:0] exp_v [3] = '{V_FETCH, V_ZERO, V_EX_BR};
    for (int k = 0; k < 2; k++) begin
      irOut = 32'h00208463;
      comparatorOut = (k == 1);
      #1;
      for (int c = 0; c < 3; c++) begin
        total++;
        if (outs !== exp_v[c]) begin
          bad++;
          $display("FAIL branch cmp=%0d cycle=%0d got=%b want=%b", k, c, outs, exp_v[c]);
        end
        cyc();
      end
      exp_ret++;
      total++;
      if (outs !== V_FETCH) begin bad++; $display("FAIL branch_next_fetch cmp=%0d got=%b want=%b", k, outs, V_FETCH); end
      total++;
      if (retired !== 32'(exp_ret)) begin bad++; $display("FAIL branch_retired cmp=%0d got=%0d want=%0d", k, retired, exp_ret); end
    end
    comparatorOut = 1'b0;
  endtask

  // illegal instruction: HALT after DECODE, quiet for 10 cycles, reset recovers
  task automatic test_halt(input logic [31:0] ins);
    irOut = ins;
    #1;
    total++; if (outs !== V_FETCH) begin bad++; $display("FAIL halt_fetch ins=%h got=%b want=%b", ins, outs, V_FETCH); end
    cyc();
    total++; if ({halted, outs} !== {1'b0, V_ZERO}) begin bad++; $display("FAIL halt_decode ins=%h got=%b want=%b", ins, {halted, outs}, {1'b0, V_ZERO}); end
    cyc();
    for (int c = 0; c < 10; c++) begin
      total++;
      if ({halted, outs} !== {1'b1, V_ZERO}) begin
        bad++;
        $display("FAIL halt_hold ins=%h cycle=%0d got=%b want=%b", ins, c, {halted, outs}, {1'b1, V_ZERO});
      end
      cyc();
    end
    total++; if (retired !== 32'(exp_ret)) begin bad++; $display("FAIL halt_retired_frozen got=%0d want=%0d", retired, exp_ret); end
    reset = 1'b0;
    cyc();
    total++; if ({halted, outs} !== {1'b0, V_ZERO}) begin bad++; $display("FAIL halt_cleared got=%b want=%b", {halted, outs}, {1'b0, V_ZERO}); end
    total++; if (retired !== 32'd0) begin bad++; $display("FAIL halt_reset_retired got=%0d want=0", retired); end
    reset = 1'b1;
    cyc();
    exp_ret = 0;
    total++; if (outs !== V_FETCH) begin bad++; $display("FAIL halt_restart got=%b want=%b", outs, V_FETCH); end
  endtask

  // reset during SW MEM aborts the store and restarts at FETCH
  task automatic test_reset_abort();
    logic [12:0] exp_v [4] = '{V_FETCH, V_ZERO, V_ALUSRC, V_MEM_SW};
    irOut = 32'h0020A023;
    #1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (outs !== exp_v[c]) begin
        bad++;
        $display("FAIL abort_seq cycle=%0d got=%b want=%b", c, outs, exp_v[c]);
      end
      if (c < 3) cyc();
    end
    reset = 1'b0;
    cyc();
    total++; if (outs !== V_ZERO) begin bad++; $display("FAIL abort_outs got=%b want=%b", outs, V_ZERO); end
    total++; if (retired !== 32'd0) begin bad++; $display("FAIL abort_retired got=%0d want=0", retired); end
    reset = 1'b1;
    cyc();
    total++; if (outs !== V_FETCH) begin bad++; $display("FAIL abort_restart got=%b want=%b", outs, V_FETCH); end
    cyc();
    total++; if (outs !== V_ZERO) begin bad++; $display("FAIL abort_decode got=%b want=%b", outs, V_ZERO); end
    cyc();
    cyc();
    cyc();
    total++; if ((outs !== V_FETCH) || (retired !== 32'd1)) begin bad++; $display("FAIL abort_replay got=%b/%0d want=%b/1", outs, retired, V_FETCH); end
    exp_ret = 1;
  endtask

  initial begin
    test_reset();
    test_wb_ops();
    test_load();
    test_store();
    test_branch();
    test_halt(32'h0000007F);
    test_reset_abort();
    test_halt(32'h0000B103);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/main_controller.md
MAIN_CONTROLLER -- requirements
Module: main_controller

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, giving the width of irOut and retired.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port irOut, input, DWIDTH bits: the current instruction register contents.
REQ-005 SHALL have port comparatorOut, input, 1 bit: the branch-condition result.
REQ-006 SHALL have outputs irEn, pcEn, regWrite, aluSrc, ramRdEn, ramWrEn, isByte, isHalf, isWord, each 1 bit, with the datapath meanings of the same names.
REQ-007 SHALL have outputs pcSelect and memToReg, each 2 bits.
REQ-008 SHALL have output halted, 1 bit: asserted once an illegal opcode has been decoded.
REQ-009 SHALL have output retired, DWIDTH bits: the count of completed instructions.

Function
REQ-010 SHALL implement a Moore FSM with states FETCH, DECODE, EXEC, MEM, WB and HALT; every output SHALL be a function of the registered state and irOut only.
REQ-011 FETCH SHALL assert irEn and go to DECODE; the instruction memory read is synchronous, so irOut is valid from DECODE onward.
REQ-012 DECODE SHALL assert no enables; it SHALL go to EXEC for legal opcodes and to HALT for any other opcode.
REQ-013 Legal opcodes (irOut[6:0]) SHALL be R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111 and AUIPC 0010111.
REQ-014 pcSelect encoding SHALL be: 00 = PC+4, 01 = conditional branch (the datapath uses comparatorOut), 10 = JAL target, 11 = JALR target (aluOut).
REQ-015 memToReg encoding SHALL be: 00 = ALU, 01 = data memory, 10 = pcOut, 11 = immGen.
REQ-016 aluSrc SHALL be 1 in EXEC, MEM and WB for I, LOAD, STORE, JALR and AUIPC, and 0 otherwise.
REQ-017 From EXEC the next state SHALL be MEM for LOAD and STORE, FETCH for BRANCH, and WB for all other legal opcodes.
REQ-018 BRANCH EXEC SHALL assert pcEn with pcSelect=01 and SHALL complete the instruction in 3 cycles.
REQ-019 LOAD MEM SHALL assert ramRdEn; LOAD WB SHALL assert regWrite with memToReg=01 and pcEn with pcSelect=00, completing in 5 cycles.
REQ-020 STORE MEM SHALL assert ramWrEn and pcEn with pcSelect=00, then go to FETCH, completing in 4 cycles.
REQ-021 WB SHALL assert regWrite and pcEn; pcSelect and memToReg SHALL be: R/I 00/00, AUIPC 00/00, LUI 00/11, JAL 10/10, JALR 11/10.
REQ-022 In MEM and WB of LOAD/STORE, isByte, isHalf and isWord SHALL be one-hot from irOut[13:12] (00 byte, 01 half, 10 word).
REQ-023 irOut[13:12]=11 on LOAD/STORE SHALL be treated as illegal: DECODE goes to HALT.
REQ-024 pcEn SHALL pulse for exactly one cycle per instruction, in that instruction's final state, and WB SHALL always return to FETCH.
REQ-025 retired SHALL increment by 1 on each cycle in which pcEn is asserted and SHALL wrap from all-ones to 0.
REQ-026 HALT SHALL hold halted=1 with all enables 0 until reset; retired SHALL freeze in HALT.
REQ-027 irOut SHALL only be decoded in DECODE, EXEC, MEM and WB; irOut contents during FETCH are don't-care.

Reset
REQ-028 While reset=0 at a rising clk edge, the next state SHALL be FETCH, retired SHALL become 0 and halted SHALL become 0.
REQ-029 While the state is in reset, all enables, pcSelect, memToReg and the size strobes SHALL be 0.
REQ-030 Reset asserted mid-instruction (including in MEM with ramWrEn high) SHALL abort the instruction with no further pcEn or regWrite, and SHALL restart at FETCH on the first edge with reset=1.

Structure
REQ-031 A shared package SHALL hold the state enumeration, the opcode constants and the pcSelect and memToReg encodings; the datapath SHALL import the same encodings.
REQ-032 A single sub-module, opcode_decoder (combinational: irOut -> instruction class plus illegal flag), SHALL be used by the FSM; the state register and retired counter SHALL live in main_controller.

Verification
REQ-033 Scenario: reset=0 for 2 cycles, then 1 -> irEn=1 on the first cycle; retired=0; halted=0.
REQ-034 Scenario: ADD 0x002081B3 -> FETCH, DECODE, EXEC, WB; WB has regWrite=1, memToReg=00, pcEn=1, pcSelect=00; retired increments by 1.
REQ-035 Scenario: LW 0x0000A103 -> ramRdEn=1 with isWord=1 in MEM; WB has memToReg=01; 5 cycles in total.
REQ-036 Scenario: BEQ 0x00208463 with comparatorOut=0 and then =1 -> pcEn=1 with pcSelect=01 in EXEC in both cases; the next state is FETCH.
REQ-037 Scenario: opcode 0x0000007F -> HALT after DECODE; halted=1; no enables asserted for 10 cycles; the next reset clears halted.
REQ-038 Scenario: reset=0 during STORE MEM -> the next cycle is FETCH state with all outputs 0; retired is unchanged from 0.
